// File: rtl/paralelo_serial.sv
// Parallel-to-serial bit-clock stage: WIDTH-bit words in through ready/valid,
// MSB-first serial stream out, padded with IDLE_SYM whenever no word is offered.
module paralelo_serial #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] IDLE_SYM   = WIDTH'(8'hBC),
    parameter int               INIT_WORDS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             frame_start,
    output logic             is_data
);

    localparam int CW = $clog2(WIDTH);
    localparam int IW = $clog2(INIT_WORDS + 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_WORDS);

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_INIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IW-1:0]    init_cnt_r;
    logic [IW-1:0]    init_cnt_nxt_s;
    logic [CW-1:0]    bit_cnt_r;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] word_s;
    logic             load_s;
    logic             ready_s;
    logic             take_s;
    logic             data_out_r;
    logic             frame_start_r;
    logic             is_data_r;

    // Slot timing: a word is loaded on the first START edge and whenever the last bit is on the line.
    always_comb begin
        load_s  = 1'b0;
        ready_s = 1'b0;
        if (state_r == ST_START) begin
            load_s = 1'b1;
        end else if (bit_cnt_r == LAST_BIT) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
        ready_s = (state_r == ST_ACTIVE) && (bit_cnt_r == LAST_BIT);
        take_s  = ready_s && valid_in;
        word_s  = take_s ? data_in : IDLE_SYM;
    end

    // Next-state: count idle words through init, then stay ACTIVE until reset.
    always_comb begin
        state_nxt_s    = state_r;
        init_cnt_nxt_s = init_cnt_r;
        case (state_r)
            ST_START: begin
                init_cnt_nxt_s = IW'(1);
                if (INIT_WORDS == 1) begin
                    state_nxt_s = ST_ACTIVE;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_INIT: begin
                if (load_s) begin
                    init_cnt_nxt_s = init_cnt_r + IW'(1);
                    if ((init_cnt_r + IW'(1)) == INIT_LAST) begin
                        state_nxt_s = ST_ACTIVE;
                    end else begin
                        state_nxt_s = ST_INIT;
                    end
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_ACTIVE: begin
                state_nxt_s = ST_ACTIVE;
            end
            default: begin
                state_nxt_s    = ST_START;
                init_cnt_nxt_s = {IW{1'b0}};
            end
        endcase
    end

    // State and init counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_START;
            init_cnt_r <= {IW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            init_cnt_r <= init_cnt_nxt_s;
        end
    end

    // Serialiser: the shift register holds the not-yet-sent bits left-aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_r     <= {CW{1'b0}};
            shift_r       <= {WIDTH{1'b0}};
            data_out_r    <= 1'b0;
            frame_start_r <= 1'b0;
            is_data_r     <= 1'b0;
        end else if (load_s) begin
            bit_cnt_r     <= {CW{1'b0}};
            shift_r       <= {word_s[WIDTH-2:0], 1'b0};
            data_out_r    <= word_s[WIDTH-1];
            frame_start_r <= 1'b1;
            is_data_r     <= take_s;
        end else begin
            bit_cnt_r     <= bit_cnt_r + CW'(1);
            shift_r       <= {shift_r[WIDTH-2:0], 1'b0};
            data_out_r    <= shift_r[WIDTH-1];
            frame_start_r <= 1'b0;
            is_data_r     <= is_data_r;
        end
    end

    assign ready_out   = ready_s;
    assign data_out    = data_out_r;
    assign frame_start = frame_start_r;
    assign is_data     = is_data_r;

endmodule

// File: tb/tb_paralelo_serial.sv
// Self-checking bench for paralelo_serial: default 8-bit instance and a 10-bit,
// single-init-word instance, both checked against a slot-based reference model.
module tb_paralelo_serial;

    logic       clk = 1'b0;
    logic [1:0] rst;
    logic [1:0] vld;
    logic [9:0] din [2];
    wire  [1:0] dout;
    wire  [1:0] fs;
    wire  [1:0] isd;
    wire  [1:0] rdy;

    int         wd [2];
    int         initw [2];
    int         n [2];
    logic [9:0] idle [2];
    logic [9:0] cur_word [2];
    logic       cur_isdata [2];

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    paralelo_serial #(.WIDTH(8), .IDLE_SYM(8'hBC), .INIT_WORDS(4)) dut_a (
        .clk(clk), .reset(rst[0]), .data_in(din[0][7:0]), .valid_in(vld[0]),
        .ready_out(rdy[0]), .data_out(dout[0]), .frame_start(fs[0]), .is_data(isd[0])
    );

    paralelo_serial #(.WIDTH(10), .IDLE_SYM(10'h17C), .INIT_WORDS(1)) dut_b (
        .clk(clk), .reset(rst[1]), .data_in(din[1]), .valid_in(vld[1]),
        .ready_out(rdy[1]), .data_out(dout[1]), .frame_start(fs[1]), .is_data(isd[1])
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input int d, input string where);
        check($sformatf("%s data_out d%0d", where, d), dout[d], 1'b0);
        check($sformatf("%s frame_start d%0d", where, d), fs[d], 1'b0);
        check($sformatf("%s is_data d%0d", where, d), isd[d], 1'b0);
        check($sformatf("%s ready_out d%0d", where, d), rdy[d], 1'b0);
    endtask

    // Reference: edges are numbered from reset release; every wd edges starts a new slot.
    // The first initw slots are idle; later slots carry data_in if valid_in is high at
    // the slot's first edge, otherwise the idle symbol.
    task automatic tick(input int d);
        int   pos;
        logic exp_rdy;
        if (n[d] % wd[d] == 0) begin
            if ((n[d] / wd[d]) >= initw[d] && vld[d] === 1'b1) begin
                cur_word[d]   = din[d];
                cur_isdata[d] = 1'b1;
            end else begin
                cur_word[d]   = idle[d];
                cur_isdata[d] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        n[d]++;
        pos     = (n[d] - 1) % wd[d];
        exp_rdy = (n[d] >= initw[d] * wd[d]) && (n[d] % wd[d] == 0);
        check($sformatf("data_out d%0d edge%0d", d, n[d]), dout[d], cur_word[d][wd[d] - 1 - pos]);
        check($sformatf("frame_start d%0d edge%0d", d, n[d]), fs[d], (pos == 0));
        check($sformatf("is_data d%0d edge%0d", d, n[d]), isd[d], cur_isdata[d]);
        check($sformatf("ready_out d%0d edge%0d", d, n[d]), rdy[d], exp_rdy);
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero(d, "in_reset");
        @(negedge clk);
        rst[d] = 1'b1;
        n[d]   = 0;
    endtask

    initial begin
        rst         = 2'b00;
        vld         = 2'b00;
        din[0]      = 10'(($urandom_range(0, 255)));
        din[1]      = 10'(($urandom_range(0, 1023)));
        wd[0]       = 8;
        wd[1]       = 10;
        initw[0]    = 4;
        initw[1]    = 1;
        idle[0]     = 10'h0BC;
        idle[1]     = 10'h17C;
        n[0]        = 0;
        n[1]        = 0;
        cur_word[0] = 10'h000;
        cur_word[1] = 10'h000;
        cur_isdata[0] = 1'b0;
        cur_isdata[1] = 1'b0;

        // Init sequence: four idle words, ready only after edge 32.
        do_reset(0);
        repeat (32) tick(0);

        // A5 taken at edge 33, then 01 and FF back to back with valid held.
        din[0] = 10'h0A5;
        vld[0] = 1'b1;
        tick(0);
        din[0] = 10'h001;
        repeat (7) tick(0);
        tick(0);
        din[0] = 10'h0FF;
        repeat (7) tick(0);
        tick(0);

        // One empty slot, plus a valid pulse while not ready.
        vld[0] = 1'b0;
        repeat (7) tick(0);
        tick(0);
        repeat (3) tick(0);
        vld[0] = 1'b1;
        din[0] = 10'h03C;
        tick(0);
        vld[0] = 1'b0;
        repeat (3) tick(0);

        // Random traffic, one decision per slot; valid toggles mid-slot are ignored.
        for (int s = 0; s < 12; s++) begin
            vld[0] = 1'($urandom_range(0, 1));
            din[0] = 10'($urandom_range(0, 255));
            tick(0);
            for (int k = 0; k < 7; k++) begin
                vld[0] = 1'($urandom_range(0, 1));
                tick(0);
            end
        end

        // Reset at bit 3 of a data word: outputs clear at once, init restarts.
        vld[0] = 1'b1;
        din[0] = 10'h096;
        tick(0);
        vld[0] = 1'b0;
        repeat (3) tick(0);
        #1;
        rst[0] = 1'b0;
        #1;
        check_zero(0, "mid_reset");
        do_reset(0);
        vld[0] = 1'b1;
        din[0] = 10'h05A;
        repeat (32) tick(0);
        tick(0);
        vld[0] = 1'b0;
        repeat (15) tick(0);
        rst[0] = 1'b0;

        // 10-bit instance with a single init word.
        do_reset(1);
        repeat (10) tick(1);
        for (int s = 0; s < 8; s++) begin
            vld[1] = 1'($urandom_range(0, 1));
            din[1] = 10'($urandom_range(0, 1023));
            tick(1);
            repeat (9) tick(1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
